// File: rtl/aes_bist_if.sv
// Vector ROM and AES-core bus seen by the BIST harness.
// master = harness side, slave = ROM/DUT side.
interface aes_bist_if #(
    parameter int DATA_W = 128,
    parameter int KEY_W  = 256,
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] stim_addr;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] rd_plain;
    logic [KEY_W-1:0]  rd_key;
    logic [DATA_W-1:0] rd_cipher;
    logic [DATA_W-1:0] stim_state;
    logic [KEY_W-1:0]  stim_key;
    logic              stim_valid;
    logic [DATA_W-1:0] dut_out;

    modport master (
        output stim_addr, exp_addr, stim_state, stim_key, stim_valid,
        input  rd_plain, rd_key, rd_cipher, dut_out
    );
    modport slave (
        input  stim_addr, exp_addr, stim_state, stim_key, stim_valid,
        output rd_plain, rd_key, rd_cipher, dut_out
    );
endinterface

// File: rtl/aes_vector_bist.sv
// Streams ROM vectors into a pipelined AES core and checks its output LATENCY cycles later,
// with stall bubbles, optional stop-on-first-error, error count and first-failure capture.
module aes_vector_bist #(
    parameter int DATA_W      = 128,
    parameter int KEY_W       = 256,
    parameter int LATENCY     = 29,
    parameter int NUM_VEC     = 500,
    parameter int ADDR_W      = 9,
    parameter int STOP_ON_ERR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    aes_bist_if.master        bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic              first_err_vld
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] NV      = (ADDR_W+1)'(NUM_VEC);
    localparam logic [ADDR_W:0] NV_LAST = NV - 1'b1;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   issue_cnt, chk_cnt;
    logic [ADDR_W-1:0] fetch_cnt, last_addr;
    logic              iss_d;
    // vld_pipe[0] is stim_valid itself; vld_pipe[k] is stim_valid delayed k cycles
    logic [LATENCY:0]  vld_pipe;
    logic              active, enter_run, issue, cmp, mis;

    assign active    = (state == RUN) || (state == DRAIN);
    assign enter_run = start && ((state == IDLE) || (state == DONE));
    assign issue     = (state == RUN) && !stall && (issue_cnt != NV);
    assign cmp       = active && vld_pipe[LATENCY];
    assign mis       = cmp && (bus.dut_out != bus.rd_cipher);

    // Address goes out combinationally so the sync ROM returns data the next cycle
    assign bus.stim_addr  = issue ? issue_cnt[ADDR_W-1:0] : last_addr;
    assign bus.exp_addr   = fetch_cnt;
    assign bus.stim_valid = vld_pipe[0];
    assign pass           = done && (err_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (mis && STOP_ON_ERR != 0) state_nxt = DONE;
                else if (issue_cnt == NV)    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (mis && STOP_ON_ERR != 0)                      state_nxt = DONE;
                else if ((cmp && chk_cnt == NV_LAST) || chk_cnt == NV) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt      <= '0;
            chk_cnt        <= '0;
            fetch_cnt      <= '0;
            last_addr      <= '0;
            iss_d          <= 1'b0;
            vld_pipe       <= '0;
            bus.stim_state <= '0;
            bus.stim_key   <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_vld  <= 1'b0;
        end else if (enter_run) begin
            // Flush anything still in flight from an aborted (stop-on-error) run
            issue_cnt      <= '0;
            chk_cnt        <= '0;
            fetch_cnt      <= '0;
            iss_d          <= 1'b0;
            vld_pipe       <= '0;
            bus.stim_state <= '0;
            bus.stim_key   <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_vld  <= 1'b0;
        end else begin
            iss_d          <= issue;
            bus.stim_state <= iss_d ? bus.rd_plain : '0;
            bus.stim_key   <= iss_d ? bus.rd_key   : '0;
            vld_pipe       <= {vld_pipe[LATENCY-1:0], iss_d};
            if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
                last_addr <= issue_cnt[ADDR_W-1:0];
            end
            if (vld_pipe[LATENCY-1]) fetch_cnt <= fetch_cnt + 1'b1;
            if (cmp)                 chk_cnt   <= chk_cnt + 1'b1;
            if (mis) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (!first_err_vld) begin
                    first_err_idx <= chk_cnt[ADDR_W-1:0];
                    first_err_vld <= 1'b1;
                end
            end
        end
    end
endmodule
